// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks.
//
// Contents:
//   NUM_DIGITS_DEF : default number of multiplexed digits
//   IDX_W          : width of a digit index for the default digit count
//   seg_idx_t      : digit index type for the default digit count
//   SEG_0..SEG_F   : active-low segment patterns {g,f,e,d,c,b,a}, a = bit 0
//   SEG_BLANK      : all segments off
package seg_pkg;

  localparam int NUM_DIGITS_DEF = 4;
  localparam int IDX_W          = $clog2(NUM_DIGITS_DEF);

  typedef logic [IDX_W-1:0] seg_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_display_scan_if.sv
// Display bus between the digit datapath and the scan driver.
//
// Signals:
//   digits     : hex nibble per digit, digit i = digits[4i+3:4i], digit 0 rightmost
//   blink_mask : 1 = digit blanks while the blink clock is high
//   dp_mask    : 1 = decimal point lit on that digit
//   an         : active-low anode enables (driven by the scanner)
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//
// Modports:
//   master : datapath side, supplies digits/masks, observes the pins
//   slave  : scanner side, consumes digits/masks, drives the pins
interface seg_display_scan_if #(
  parameter int NUM_DIGITS = seg_pkg::NUM_DIGITS_DEF
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  modport master (
    output digits, blink_mask, dp_mask,
    input  an, seg, dp
  );

  modport slave (
    input  digits, blink_mask, dp_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
//
// Ports:
//   nibble  in  4  hex value 0..F
//   pattern out 7  active-low {g,f,e,d,c,b,a}, a = bit 0
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment scan driver.
//
// Samples the divided fast_clk level in the master_clk domain, turns each
// rising edge into a one-cycle scan strobe and steps a ring index across
// the digits. Anode, segment and decimal-point pins are registered and
// active-low, with per-digit blink blanking.
//
// Ports:
//   master_clk in  1  system clock, rising edge
//   RESET      in  1  synchronous active-high reset
//   fast_clk   in  1  divided scan clock level
//   blink_clk  in  1  divided blink clock level
//   bus        slave modport of seg_display_scan_if (digits, masks, an/seg/dp)
//
// Optional feature:
//   SEG_LEADING_ZERO_BLANK_EN : when defined, digit i >= 1 is blanked while
//   digits i..NUM_DIGITS-1 are all zero, unless that digit's dp_mask bit is set.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
)(
  input  logic               master_clk,
  input  logic               RESET,
  input  logic               fast_clk,
  input  logic               blink_clk,
  seg_display_scan_if.slave  bus
);

  localparam int               LOC_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [LOC_IDX_W-1:0] LAST_IDX = LOC_IDX_W'(NUM_DIGITS - 1);

  logic [LOC_IDX_W-1:0]  idx;
  logic                  fast_q;
  logic                  tick;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_pattern;
  logic                  cur_blink;
  logic                  cur_dp;
  logic                  cur_lz_blank;
  logic [NUM_DIGITS-1:0] an_sel;

  // fast_q resets high so a fast_clk already high out of reset is not a tick.
  assign tick = fast_clk & ~fast_q;

  // Select the current digit's nibble, masks and anode pattern.
  always_comb begin
    cur_nibble = 4'h0;
    cur_blink  = 1'b0;
    cur_dp     = 1'b0;
    an_sel     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == LOC_IDX_W'(i)) begin
        cur_nibble = bus.digits[4*i +: 4];
        cur_blink  = bus.blink_mask[i];
        cur_dp     = bus.dp_mask[i];
        an_sel[i]  = 1'b0;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_above;

  // zero_above[i] is set when digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_above = '0;
    zero_above[NUM_DIGITS-1] = (bus.digits[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] & (bus.digits[4*i +: 4] == 4'h0);
    end
  end

  // Digit 0 always shows; a lit decimal point keeps its digit visible.
  always_comb begin
    cur_lz_blank = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx == LOC_IDX_W'(i)) begin
        cur_lz_blank = zero_above[i] & ~bus.dp_mask[i];
      end
    end
  end
`else
  always_comb begin
    cur_lz_blank = 1'b0;
  end
`endif

  seg_hex_decoder u_decoder (
    .nibble  (cur_nibble),
    .pattern (cur_pattern)
  );

  // Scan index ring and registered pin outputs; outputs follow the index
  // register, so a new index shows on the pins one cycle after it updates.
  always_ff @(posedge master_clk) begin
    if (RESET) begin
      idx     <= '0;
      fast_q  <= 1'b1;
      bus.an  <= '1;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      fast_q <= fast_clk;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if ((cur_blink && blink_clk) || cur_lz_blank) begin
        bus.an  <= '1;
        bus.seg <= SEG_BLANK;
        bus.dp  <= 1'b1;
      end else begin
        bus.an  <= an_sel;
        bus.seg <= cur_pattern;
        bus.dp  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed testbench for seg_display_scan (4 digits).
// Build with +define+SEG_LEADING_ZERO_BLANK_EN to cover the leading-zero option.
module tb_seg_display_scan;
  import seg_pkg::*;

  logic master_clk = 1'b0;
  logic RESET      = 1'b1;
  logic fast_clk   = 1'b1;
  logic blink_clk  = 1'b0;

  int checks = 0;
  int errors = 0;

  seg_idx_t tb_idx;

  seg_display_scan_if #(.NUM_DIGITS(4)) bus ();

  seg_display_scan #(.NUM_DIGITS(4)) dut (
    .master_clk (master_clk),
    .RESET      (RESET),
    .fast_clk   (fast_clk),
    .blink_clk  (blink_clk),
    .bus        (bus)
  );

  always #5 master_clk = ~master_clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  // One fast_clk pulse: index moves on the first edge, pins show it after the second.
  task automatic tick_once();
    fast_clk = 1'b1;
    step();
    fast_clk = 1'b0;
    step();
    tb_idx = tb_idx + 1'b1;
  endtask

  task automatic test_reset();
    bus.digits     = 16'h4321;
    bus.blink_mask = 4'b0000;
    bus.dp_mask    = 4'b0000;
    blink_clk      = 1'b0;
    fast_clk       = 1'b1;
    RESET          = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an got %b exp %b", bus.an, 4'b1111); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("[TB] FAIL reset_seg got %b exp %b", bus.seg, 7'b1111111); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp got %b exp %b", bus.dp, 1'b1); end
    RESET = 1'b0;
    tb_idx = '0;
    step();
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("[TB] FAIL release_an got %b exp %b", bus.an, 4'b1110); end
    checks++; if (bus.seg !== 7'b1111001) begin errors++; $display("[TB] FAIL release_seg got %b exp %b", bus.seg, 7'b1111001); end
    step();
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("[TB] FAIL release_no_tick_an got %b exp %b", bus.an, 4'b1110); end
  endtask

  task automatic test_scan_wrap();
    logic [3:0] exp_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] exp_seg [4] = '{7'b0100100, 7'b0110000, 7'b0011001, 7'b1111001};
    fast_clk = 1'b0;
    step();
    step();
    for (int p = 0; p < 4; p++) begin
      fast_clk = 1'b1;
      for (int c = 0; c < 5; c++) step();
      checks++; if (bus.an !== exp_an[p]) begin errors++; $display("[TB] FAIL scan_an[%0d] got %b exp %b", p, bus.an, exp_an[p]); end
      checks++; if (bus.seg !== exp_seg[p]) begin errors++; $display("[TB] FAIL scan_seg[%0d] got %b exp %b", p, bus.seg, exp_seg[p]); end
      fast_clk = 1'b0;
      for (int c = 0; c < 3; c++) step();
      checks++; if (bus.an !== exp_an[p]) begin errors++; $display("[TB] FAIL scan_hold_an[%0d] got %b exp %b", p, bus.an, exp_an[p]); end
    end
    tb_idx = '0;
  endtask

  task automatic test_decode();
    logic [6:0] table_seg [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int n = 0; n < 16; n++) begin
      bus.digits = {12'h432, 4'(n)};
      step();
      checks++; if (bus.seg !== table_seg[n]) begin errors++; $display("[TB] FAIL decode_%h got %b exp %b", n, bus.seg, table_seg[n]); end
    end
    bus.digits = 16'h4321;
    step();
  endtask

  task automatic test_blink();
    bus.blink_mask = 4'b0010;
    blink_clk      = 1'b1;
    tick_once();
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("[TB] FAIL blink_on_an got %b exp %b", bus.an, 4'b1111); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("[TB] FAIL blink_on_seg got %b exp %b", bus.seg, 7'b1111111); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("[TB] FAIL blink_on_dp got %b exp %b", bus.dp, 1'b1); end
    blink_clk = 1'b0;
    step();
    checks++; if (bus.an !== 4'b1101) begin errors++; $display("[TB] FAIL blink_off_an got %b exp %b", bus.an, 4'b1101); end
    checks++; if (bus.seg !== 7'b0100100) begin errors++; $display("[TB] FAIL blink_off_seg got %b exp %b", bus.seg, 7'b0100100); end
    blink_clk = 1'b1;
    tick_once();
    checks++; if (bus.an !== 4'b1011) begin errors++; $display("[TB] FAIL blink_other_an got %b exp %b", bus.an, 4'b1011); end
    checks++; if (bus.seg !== 7'b0110000) begin errors++; $display("[TB] FAIL blink_other_seg got %b exp %b", bus.seg, 7'b0110000); end
    bus.blink_mask = 4'b0000;
    blink_clk      = 1'b0;
  endtask

  task automatic test_dp();
    bus.dp_mask = 4'b0100;
    step();
    checks++; if (bus.dp !== 1'b0) begin errors++; $display("[TB] FAIL dp_idx2 got %b exp %b", bus.dp, 1'b0); end
    for (int k = 0; k < 3; k++) begin
      tick_once();
      checks++; if (bus.dp !== 1'b1) begin errors++; $display("[TB] FAIL dp_idx%0d got %b exp %b", tb_idx, bus.dp, 1'b1); end
    end
    tick_once();
    checks++; if (bus.dp !== 1'b0) begin errors++; $display("[TB] FAIL dp_idx2_again got %b exp %b", bus.dp, 1'b0); end
    checks++; if (bus.an !== 4'b1011) begin errors++; $display("[TB] FAIL dp_idx2_an got %b exp %b", bus.an, 4'b1011); end
    bus.dp_mask = 4'b0000;
  endtask

  task automatic test_leading_zero();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    bus.digits = 16'h0050;
    step();
    for (int k = 0; k < 4; k++) begin
      case (tb_idx)
`ifdef SEG_LEADING_ZERO_BLANK_EN
        2'd3: begin exp_an = 4'b1111; exp_seg = 7'b1111111; end
        2'd2: begin exp_an = 4'b1111; exp_seg = 7'b1111111; end
`else
        2'd3: begin exp_an = 4'b0111; exp_seg = 7'b1000000; end
        2'd2: begin exp_an = 4'b1011; exp_seg = 7'b1000000; end
`endif
        2'd1:    begin exp_an = 4'b1101; exp_seg = 7'b0010010; end
        default: begin exp_an = 4'b1110; exp_seg = 7'b1000000; end
      endcase
      checks++; if (bus.an !== exp_an) begin errors++; $display("[TB] FAIL lz_an_idx%0d got %b exp %b", tb_idx, bus.an, exp_an); end
      checks++; if (bus.seg !== exp_seg) begin errors++; $display("[TB] FAIL lz_seg_idx%0d got %b exp %b", tb_idx, bus.seg, exp_seg); end
      tick_once();
    end
    // tb_idx is 2 again; move to digit 3 and light its decimal point.
    tick_once();
    bus.dp_mask = 4'b1000;
    step();
    checks++; if (bus.an !== 4'b0111) begin errors++; $display("[TB] FAIL lz_dp_override_an got %b exp %b", bus.an, 4'b0111); end
    checks++; if (bus.seg !== 7'b1000000) begin errors++; $display("[TB] FAIL lz_dp_override_seg got %b exp %b", bus.seg, 7'b1000000); end
    checks++; if (bus.dp !== 1'b0) begin errors++; $display("[TB] FAIL lz_dp_override_dp got %b exp %b", bus.dp, 1'b0); end
    bus.dp_mask = 4'b0000;
  endtask

  task automatic test_reset_during_tick();
    fast_clk = 1'b0;
    step();
    RESET    = 1'b1;
    fast_clk = 1'b1;
    step();
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_tick_an got %b exp %b", bus.an, 4'b1111); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("[TB] FAIL reset_tick_seg got %b exp %b", bus.seg, 7'b1111111); end
    RESET = 1'b0;
    tb_idx = '0;
    step();
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("[TB] FAIL reset_tick_release_an got %b exp %b", bus.an, 4'b1110); end
    checks++; if (bus.seg !== 7'b1000000) begin errors++; $display("[TB] FAIL reset_tick_release_seg got %b exp %b", bus.seg, 7'b1000000); end
    step();
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("[TB] FAIL reset_tick_hold_an got %b exp %b", bus.an, 4'b1110); end
  endtask

  initial begin
    $display("[TB] seg_display_scan directed test start");
    test_reset();
    test_scan_wrap();
    test_decode();
    test_blink();
    test_dp();
    test_leading_zero();
    test_reset_during_tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
